mode_fsm: RTL and testbench

MODE_FSM -- requirements
Module: mode_fsm

---
 rtl/mode_fsm.sv | 107 ++++++++++
 tb/tb_mode_fsm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mode_fsm.sv
// Fan mode sequencer: OFF/STANDBY/fan levels plus timed LEVEL3 (hurricane) and CLEAN runs.
// state | meaning: OFF 0 powered down | STANDBY 1 idle | LEVEL1/2 2,3 fan | LEVEL3 4 timed boost | CLEAN 5 timed self-clean
module mode_fsm #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int HURRICANE_SEC = 60,
  parameter int CLEAN_SEC     = 180
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       power_toggle,
  input  logic       standby_pulse,
  input  logic       level1_pulse,
  input  logic       level2_pulse,
  input  logic       level3_pulse,
  input  logic       clean_pulse,
  output logic [2:0] current_mode,
  output logic [7:0] countdown,
  output logic       hurricane_used
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  typedef enum logic [2:0] {
    OFF_MODE     = 3'd0,
    STANDBY_MODE = 3'd1,
    LEVEL1_MODE  = 3'd2,
    LEVEL2_MODE  = 3'd3,
    LEVEL3_MODE  = 3'd4,
    CLEAN_MODE   = 3'd5
  } mode_t;

  mode_t         mode;
  mode_t         nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic          timed;
  logic          expire;

  // Each branch tests only the pulses legal in that mode, highest priority first,
  // so an illegal higher-priority pulse falls through to the next legal one.
  always_comb begin
    tick   = (presc == PRESC_MAX);
    timed  = (mode == LEVEL3_MODE) || (mode == CLEAN_MODE);
    expire = timed && tick && (countdown == 8'd1);
    nxt    = mode;
    case (mode)
      OFF_MODE: begin
        if (power_toggle) nxt = STANDBY_MODE;
      end
      STANDBY_MODE: begin
        if (power_toggle)                         nxt = OFF_MODE;
        else if (level3_pulse && !hurricane_used) nxt = LEVEL3_MODE;
        else if (level2_pulse)                    nxt = LEVEL2_MODE;
        else if (level1_pulse)                    nxt = LEVEL1_MODE;
        else if (clean_pulse)                     nxt = CLEAN_MODE;
      end
      LEVEL1_MODE: begin
        if (power_toggle)       nxt = OFF_MODE;
        else if (standby_pulse) nxt = STANDBY_MODE;
        else if (level2_pulse)  nxt = LEVEL2_MODE;
      end
      LEVEL2_MODE: begin
        if (power_toggle)       nxt = OFF_MODE;
        else if (standby_pulse) nxt = STANDBY_MODE;
        else if (level1_pulse)  nxt = LEVEL1_MODE;
      end
      LEVEL3_MODE: begin
        if (power_toggle) nxt = OFF_MODE;
        else if (expire)  nxt = LEVEL2_MODE;
      end
      CLEAN_MODE: begin
        if (power_toggle) nxt = OFF_MODE;
        else if (expire)  nxt = STANDBY_MODE;
      end
      default: nxt = OFF_MODE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode           <= OFF_MODE;
      countdown      <= 8'd0;
      hurricane_used <= 1'b0;
      presc          <= '0;
    end else begin
      mode <= nxt;
      if (nxt != mode) begin
        // Restart the second prescaler so the first decrement is a full second after entry.
        presc <= '0;
        case (nxt)
          LEVEL3_MODE: countdown <= 8'(HURRICANE_SEC);
          CLEAN_MODE:  countdown <= 8'(CLEAN_SEC);
          default:     countdown <= 8'd0;
        endcase
        if (nxt == OFF_MODE)         hurricane_used <= 1'b0;
        else if (nxt == LEVEL3_MODE) hurricane_used <= 1'b1;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (timed && tick && (countdown > 8'd1)) countdown <= countdown - 8'd1;
      end
    end
  end

  assign current_mode = mode;

endmodule

// File: tb/tb_mode_fsm.sv
// Directed bench for mode_fsm with a 4-cycle second, 3 s hurricane and 2 s clean run.
module tb_mode_fsm;

  localparam int M_OFF = 0, M_SB = 1, M_L1 = 2, M_L2 = 3, M_L3 = 4, M_CL = 5;
  // request vector bits: {power, standby, level3, level2, level1, clean}
  localparam logic [5:0] R_PT = 6'b100000, R_SB = 6'b010000, R_L3 = 6'b001000,
                         R_L2 = 6'b000100, R_L1 = 6'b000010, R_CL = 6'b000001;

  logic       clk;
  logic       rstn;
  logic [5:0] req;
  logic [2:0] current_mode;
  logic [7:0] countdown;
  logic       hurricane_used;

  int n_cmp = 0;
  int n_err = 0;

  mode_fsm #(.CLK_FREQ(4), .HURRICANE_SEC(3), .CLEAN_SEC(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .power_toggle   (req[5]),
    .standby_pulse  (req[4]),
    .level3_pulse   (req[3]),
    .level2_pulse   (req[2]),
    .level1_pulse   (req[1]),
    .clean_pulse    (req[0]),
    .current_mode   (current_mode),
    .countdown      (countdown),
    .hurricane_used (hurricane_used)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int m, input int cd, input logic hu);
    check({tag, ".mode"}, {5'd0, current_mode}, 8'(m));
    check({tag, ".countdown"}, countdown, 8'(cd));
    check({tag, ".hurricane"}, {7'd0, hurricane_used}, {7'd0, hu});
  endtask

  // Drive a one-cycle request; returns 1 time unit after the sampling edge.
  task automatic pulse(input logic [5:0] p);
    @(negedge clk);
    req = p;
    @(posedge clk);
    #1;
    req = 6'd0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req  = 6'd0;
    rstn = 1'b0;
    #12;
    check_all("reset", M_OFF, 0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    wait_cycles(2);
    check_all("post_reset", M_OFF, 0, 1'b0);

    pulse(R_PT);  check_all("power_on", M_SB, 0, 1'b0);
    pulse(R_PT);  check_all("power_off", M_OFF, 0, 1'b0);
    pulse(R_L1);  check_all("off_ignores_l1", M_OFF, 0, 1'b0);
    pulse(R_PT);  check_all("power_on2", M_SB, 0, 1'b0);

    // Hurricane run: entry, decrements every 4 cycles, expiry into LEVEL2 at cycle 12.
    pulse(R_L3);    check_all("l3_entry", M_L3, 3, 1'b1);
    wait_cycles(4); check_all("l3_t4", M_L3, 2, 1'b1);
    wait_cycles(4); check_all("l3_t8", M_L3, 1, 1'b1);
    wait_cycles(4); check_all("l3_expire", M_L2, 0, 1'b1);

    pulse(R_SB);        check_all("l2_to_sb", M_SB, 0, 1'b1);
    pulse(R_L3);        check_all("l3_locked", M_SB, 0, 1'b1);
    pulse(R_L3 | R_L2); check_all("l3_locked_l2_wins", M_L2, 0, 1'b1);
    pulse(R_SB);        check_all("back_sb", M_SB, 0, 1'b1);
    pulse(R_PT);        check_all("off_clears_hu", M_OFF, 0, 1'b0);
    pulse(R_PT);        check_all("on_again", M_SB, 0, 1'b0);
    pulse(R_L3);        check_all("l3_reentry", M_L3, 3, 1'b1);

    // Ignored standby on the first tick edge, then power toggle on the expiry edge.
    wait_cycles(3);
    pulse(R_SB);    check_all("l3_ignores_sb", M_L3, 2, 1'b1);
    wait_cycles(7);
    pulse(R_PT);    check_all("pt_beats_expiry", M_OFF, 0, 1'b0);

    pulse(R_PT);        check_all("on3", M_SB, 0, 1'b0);
    pulse(R_L1);        check_all("sb_to_l1", M_L1, 0, 1'b0);
    pulse(R_PT | R_L2); check_all("pt_beats_l2", M_OFF, 0, 1'b0);
    pulse(R_PT);        check_all("on4", M_SB, 0, 1'b0);

    // Clean run, with a level1 request landing on the first tick edge.
    pulse(R_CL);    check_all("clean_entry", M_CL, 2, 1'b0);
    wait_cycles(3);
    pulse(R_L1);    check_all("clean_ignores_l1", M_CL, 1, 1'b0);
    wait_cycles(4); check_all("clean_expire", M_SB, 0, 1'b0);

    pulse(R_L1);  check_all("sb_l1", M_L1, 0, 1'b0);
    pulse(R_L2);  check_all("l1_l2", M_L2, 0, 1'b0);
    pulse(R_L1);  check_all("l2_l1", M_L1, 0, 1'b0);
    pulse(R_CL);  check_all("l1_ignores_clean", M_L1, 0, 1'b0);
    pulse(R_L3);  check_all("l1_ignores_l3", M_L1, 0, 1'b0);
    pulse(R_SB);  check_all("l1_sb", M_SB, 0, 1'b0);

    // Set hurricane_used, then reset asynchronously in the middle of a clean run.
    pulse(R_L3);     check_all("l3_third", M_L3, 3, 1'b1);
    wait_cycles(12); check_all("l3_third_expire", M_L2, 0, 1'b1);
    pulse(R_SB);     check_all("sb_hu", M_SB, 0, 1'b1);
    pulse(R_CL);     check_all("clean2_entry", M_CL, 2, 1'b1);
    wait_cycles(4);  check_all("clean2_t4", M_CL, 1, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_all("async_reset", M_OFF, 0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    pulse(R_L1);  check_all("after_reset_l1", M_OFF, 0, 1'b0);
    pulse(R_PT);  check_all("after_reset_on", M_SB, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
